// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read-side drain into a 2-entry skid buffer with burst framing
module fifo_stream_reader #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [WIDTH-1:0]     FIFO_RD_DATA,
  input  logic                 FIFO_EMPTY,
  output logic                 FIFO_RD_INC,
  input  logic                 FLUSH,
  output logic [WIDTH-1:0]     OUT_DATA,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic                 OUT_LAST,
  output logic [CNT_WIDTH-1:0] WORD_CNT
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);

  // Occupancy of the skid buffer
  localparam logic [1:0] ST_EMPTY0 = 2'd0;
  localparam logic [1:0] ST_ONE    = 2'd1;
  localparam logic [1:0] ST_TWO    = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [WIDTH-1:0]  head_q;
  logic [WIDTH-1:0]  tail_q;
  logic [BEAT_W-1:0] beat;
  logic              pop;
  logic              acc;

  // Pop depends only on registered occupancy and FIFO/flush inputs, never on OUT_READY,
  // so the FIFO pointer logic sees no combinational path from the downstream sink.
  assign pop         = !FIFO_EMPTY && (state != ST_TWO) && !FLUSH;
  assign acc         = OUT_VALID && OUT_READY;
  assign FIFO_RD_INC = pop;
  assign OUT_VALID   = (state != ST_EMPTY0);
  assign OUT_DATA    = head_q;
  assign OUT_LAST    = OUT_VALID && (beat == BEAT_MAX);

  // Next occupancy; flush wins over everything
  always_comb begin
    state_nxt = state;
    if (FLUSH) begin
      state_nxt = ST_EMPTY0;
    end else begin
      case (state)
        ST_EMPTY0: if (pop) state_nxt = ST_ONE;
        ST_ONE: begin
          if (pop && !acc)      state_nxt = ST_TWO;
          else if (!pop && acc) state_nxt = ST_EMPTY0;
        end
        ST_TWO:    if (acc) state_nxt = ST_ONE;
        default:   state_nxt = ST_EMPTY0;
      endcase
    end
  end

  // Occupancy register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_EMPTY0;
    else     state <= state_nxt;
  end

  // Skid entries: new word lands in the tail, or straight in the head when the head is leaving
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_q <= '0;
      tail_q <= '0;
    end else if (!FLUSH) begin
      case (state)
        ST_EMPTY0: if (pop) head_q <= FIFO_RD_DATA;
        ST_ONE: begin
          if (pop && acc) head_q <= FIFO_RD_DATA;
          else if (pop)   tail_q <= FIFO_RD_DATA;
        end
        ST_TWO:    if (acc) head_q <= tail_q;
        default: ;
      endcase
    end
  end

  // Beat position within the current burst
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      beat <= '0;
    end else if (FLUSH) begin
      beat <= '0;
    end else if (acc) begin
      if (beat == BEAT_MAX) beat <= '0;
      else                  beat <= beat + BEAT_W'(1);
    end
  end

  // Accepted-word statistics; flush cycles are not counted
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                WORD_CNT <= '0;
    else if (acc && !FLUSH) WORD_CNT <= WORD_CNT + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - randomized bench with queue-level model of the stream reader
module tb_fifo_stream_reader;

  localparam int BL = 4;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [7:0]    FIFO_RD_DATA = 8'h00;
  logic          FIFO_EMPTY = 1'b1;
  logic          FIFO_RD_INC;
  logic          FLUSH = 1'b0;
  logic [7:0]    OUT_DATA;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b0;
  logic          OUT_LAST;
  logic [CW-1:0] WORD_CNT;

  fifo_stream_reader #(.WIDTH(8), .BURST_LEN(BL), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RST(RST), .FIFO_RD_DATA(FIFO_RD_DATA), .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_RD_INC(FIFO_RD_INC), .FLUSH(FLUSH), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OUT_LAST(OUT_LAST), .WORD_CNT(WORD_CNT)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0] fifo_q[$];   // words waiting in the upstream FIFO
  logic [7:0] sk_q[$];     // words the reader should be holding
  logic [7:0] obs_q[$];    // words seen leaving the DUT on acceptance
  int         last_q[$];   // acceptance indices where the DUT flagged last
  int         inc_cyc[$];  // cycles in which the DUT popped
  logic [7:0] words[$];
  int         beat_m = 0;
  logic [CW-1:0] cnt_m = '0;

  task automatic drive_fifo();
    FIFO_EMPTY   = (fifo_q.size() == 0);
    FIFO_RD_DATA = FIFO_EMPTY ? 8'($urandom) : fifo_q[0];
  endtask

  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
    words.push_back(w);
    drive_fifo();
  endtask

  task automatic clear_logs();
    obs_q.delete(); last_q.delete(); inc_cyc.delete(); words.delete();
  endtask

  // One clock: compare DUT against the model, then advance the model by the stream rules
  task automatic step();
    logic exp_valid, exp_inc, exp_last, acc, flush_now;
    logic [7:0] exp_data;
    @(negedge CLK);
    exp_valid = (sk_q.size() != 0);
    exp_inc   = (fifo_q.size() != 0) && (sk_q.size() < 2) && !FLUSH;
    exp_last  = exp_valid && (beat_m == BL - 1);
    exp_data  = exp_valid ? sk_q[0] : 8'h00;
    tests++;
    if (OUT_VALID !== exp_valid) begin
      fails++; $display("FAIL out_valid cyc=%0d got=%0b exp=%0b", cyc, OUT_VALID, exp_valid);
    end
    tests++;
    if (FIFO_RD_INC !== exp_inc) begin
      fails++; $display("FAIL rd_inc cyc=%0d got=%0b exp=%0b", cyc, FIFO_RD_INC, exp_inc);
    end
    tests++;
    if (OUT_LAST !== exp_last) begin
      fails++; $display("FAIL out_last cyc=%0d got=%0b exp=%0b", cyc, OUT_LAST, exp_last);
    end
    tests++;
    if (WORD_CNT !== cnt_m) begin
      fails++; $display("FAIL word_cnt cyc=%0d got=%0d exp=%0d", cyc, WORD_CNT, cnt_m);
    end
    if (exp_valid) begin
      tests++;
      if (OUT_DATA !== exp_data) begin
        fails++; $display("FAIL out_data cyc=%0d got=%02h exp=%02h", cyc, OUT_DATA, exp_data);
      end
    end
    if (FIFO_RD_INC === 1'b1) inc_cyc.push_back(cyc);
    flush_now = FLUSH;
    acc = exp_valid && OUT_READY && !flush_now;
    if (acc) begin
      if (OUT_LAST === 1'b1) last_q.push_back(obs_q.size());
      obs_q.push_back(OUT_DATA);
    end
    @(posedge CLK);
    #1;
    cyc++;
    if (flush_now) begin
      sk_q.delete();
      beat_m = 0;
    end else begin
      if (acc) begin
        void'(sk_q.pop_front());
        beat_m = (beat_m + 1) % BL;
        cnt_m  = cnt_m + 1'b1;
      end
      if (exp_inc) sk_q.push_back(fifo_q.pop_front());
    end
    drive_fifo();
  endtask

  task automatic flush_cycle();
    FLUSH = 1'b1;
    step();
    FLUSH = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    fifo_q.delete(); sk_q.delete(); beat_m = 0; cnt_m = '0;
    drive_fifo();
    repeat (2) @(posedge CLK);
    #1;
    tests++;
    if ({OUT_VALID, OUT_LAST, FIFO_RD_INC, OUT_DATA, WORD_CNT} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got v=%0b l=%0b inc=%0b d=%02h cnt=%0d exp all 0",
               OUT_VALID, OUT_LAST, FIFO_RD_INC, OUT_DATA, WORD_CNT);
    end
    RST = 1'b0;
    clear_logs();
    repeat (4) step();
    tests++;
    if (inc_cyc.size() != 0) begin
      fails++; $display("FAIL idle_no_pop got=%0d pops exp=0", inc_cyc.size());
    end
  endtask

  task automatic test_streaming();
    clear_logs();
    OUT_READY = 1'b1;
    for (int i = 1; i <= 5; i++) push(8'(i * 8'h11));
    repeat (8) step();
    tests++;
    if (inc_cyc.size() != 5 || (inc_cyc[4] - inc_cyc[0]) != 4) begin
      fails++; $display("FAIL stream_pops got=%0d pops not consecutive-5", inc_cyc.size());
    end
    tests++;
    if (obs_q.size() != 5) begin
      fails++; $display("FAIL stream_count got=%0d exp=5", obs_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests++;
        if (obs_q[i] !== 8'((i + 1) * 8'h11)) begin
          fails++; $display("FAIL stream_word%0d got=%02h exp=%02h", i, obs_q[i], 8'((i + 1) * 8'h11));
        end
      end
    end
    tests++;
    if (last_q.size() != 1 || last_q[0] != 3) begin
      fails++; $display("FAIL stream_last got=%0d flags exp=1 flag on word 3", last_q.size());
    end
    tests++;
    if (WORD_CNT !== 4'd5) begin
      fails++; $display("FAIL stream_word_cnt got=%0d exp=5", WORD_CNT);
    end
  endtask

  task automatic test_backpressure();
    clear_logs();
    OUT_READY = 1'b0;
    for (int i = 0; i < 8; i++) push(8'($urandom));
    repeat (6) step();
    tests++;
    if (inc_cyc.size() != 2) begin
      fails++; $display("FAIL bp_pops got=%0d exp=2", inc_cyc.size());
    end
    tests++;
    if (OUT_VALID !== 1'b1 || OUT_DATA !== words[0]) begin
      fails++; $display("FAIL bp_hold got=%02h v=%0b exp=%02h v=1", OUT_DATA, OUT_VALID, words[0]);
    end
    OUT_READY = 1'b1;
    repeat (14) step();
    tests++;
    if (obs_q.size() != 8) begin
      fails++; $display("FAIL bp_count got=%0d exp=8", obs_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests++;
        if (obs_q[i] !== words[i]) begin
          fails++; $display("FAIL bp_word%0d got=%02h exp=%02h", i, obs_q[i], words[i]);
        end
      end
    end
  endtask

  task automatic test_bubble();
    flush_cycle();
    clear_logs();
    for (int i = 0; i < 6; i++) push(8'($urandom));
    for (int i = 0; i < 20; i++) begin
      OUT_READY = (i % 2 == 0);
      step();
    end
    tests++;
    if (obs_q.size() != 6) begin
      fails++; $display("FAIL bubble_count got=%0d exp=6", obs_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests++;
        if (obs_q[i] !== words[i]) begin
          fails++; $display("FAIL bubble_word%0d got=%02h exp=%02h", i, obs_q[i], words[i]);
        end
      end
    end
    tests++;
    if (last_q.size() != 1 || last_q[0] != 3) begin
      fails++; $display("FAIL bubble_last got=%0d flags exp=1 flag on word 3", last_q.size());
    end
  endtask

  task automatic test_flush();
    logic [CW-1:0] saved;
    int base;
    OUT_READY = 1'b1;
    flush_cycle();
    clear_logs();
    for (int i = 0; i < 10; i++) push(8'($urandom));
    repeat (3) step();
    OUT_READY = 1'b0;
    step();
    saved = cnt_m;
    FLUSH = 1'b1; OUT_READY = 1'b1;
    step();
    FLUSH = 1'b0;
    tests++;
    if (OUT_VALID !== 1'b0) begin
      fails++; $display("FAIL flush_valid got=%0b exp=0", OUT_VALID);
    end
    tests++;
    if (WORD_CNT !== saved || obs_q.size() != 2) begin
      fails++; $display("FAIL flush_cnt got=%0d exp=%0d (accepted %0d exp 2)", WORD_CNT, saved, obs_q.size());
    end
    base = obs_q.size();
    repeat (12) step();
    tests++;
    if (last_q.size() == 0 || last_q[0] != base + 3) begin
      fails++; $display("FAIL flush_beat got first last idx=%0d exp=%0d",
                        (last_q.size() == 0) ? -1 : last_q[0], base + 3);
    end
  endtask

  task automatic test_random();
    clear_logs();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0) push(8'($urandom));
      OUT_READY = ($urandom_range(0, 3) != 0);
      FLUSH     = ($urandom_range(0, 29) == 0);
      step();
    end
    FLUSH = 1'b0; OUT_READY = 1'b1;
    repeat (fifo_q.size() + 4) step();
    tests++;
    if (fifo_q.size() != 0 || OUT_VALID !== 1'b0) begin
      fails++; $display("FAIL random_drain got fifo=%0d v=%0b exp 0/0", fifo_q.size(), OUT_VALID);
    end
  endtask

  task automatic test_async_reset();
    clear_logs();
    OUT_READY = 1'b0;
    push(8'hA5);
    step();
    if (cnt_m == '0) cnt_m = cnt_m;
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    tests++;
    if (OUT_VALID !== 1'b0 || WORD_CNT !== '0 || OUT_DATA !== 8'h00) begin
      fails++; $display("FAIL async_reset got v=%0b cnt=%0d d=%02h exp 0/0/00", OUT_VALID, WORD_CNT, OUT_DATA);
    end
    fifo_q.delete(); sk_q.delete(); beat_m = 0; cnt_m = '0;
    drive_fifo();
    @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  task automatic test_wrap();
    clear_logs();
    OUT_READY = 1'b1;
    for (int i = 0; i < 17; i++) push(8'($urandom));
    repeat (20) step();
    tests++;
    if (WORD_CNT !== 4'd1 || obs_q.size() != 17) begin
      fails++; $display("FAIL wrap got cnt=%0d accepted=%0d exp cnt=1 accepted=17", WORD_CNT, obs_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_random();
    test_async_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Read-side consumer for the asynchronous FIFO. It lives entirely in the FIFO read-clock domain and drains the FIFO through its increment/empty/data interface. Words are presented downstream on a valid/ready stream through a 2-entry skid buffer, with burst framing (last flag) and an accepted-word counter. FIFO_RD_INC is driven from registered state only, so there is no combinational path from OUT_READY to the FIFO pointer logic.

Parameters:
WIDTH, 8, data word width; must equal the FIFO data width.
BURST_LEN, 4, words per burst; OUT_LAST marks every BURST_LEN-th accepted word; legal range 1..256.
CNT_WIDTH, 16, width of the WORD_CNT statistics counter.

Ports:
CLK  input  1  read-domain clock, same clock as the FIFO read side.
RST  input  1  asynchronous, active-high reset.
FIFO_RD_DATA  input  WIDTH  FIFO head word; valid in the same cycle whenever FIFO_EMPTY=0.
FIFO_EMPTY  input  1  FIFO empty flag, registered in the CLK domain.
FIFO_RD_INC  output  1  pop strobe to FIFO; one word removed per CLK cycle it is high.
FLUSH  input  1  synchronous clear of buffer and burst counter.
OUT_DATA  output  WIDTH  stream data (head of skid buffer).
OUT_VALID  output  1  stream valid.
OUT_READY  input  1  downstream ready.
OUT_LAST  output  1  high with OUT_VALID on the final word of a burst.
WORD_CNT  output  CNT_WIDTH  count of accepted words; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Clock and reset: one clock (CLK). RST is asynchronous and active-high. While RST=1, all state is cleared: occupancy 0, burst counter 0, WORD_CNT 0, OUT_VALID=0, OUT_LAST=0, OUT_DATA=0, FIFO_RD_INC=0. Asserting RST mid-burst discards both buffered words.
- FSM on buffer occupancy, states EMPTY0/ONE/TWO.
  - pop = FIFO_RD_INC = !FIFO_EMPTY && (state != TWO) && !FLUSH.
  - acc = OUT_VALID && OUT_READY.
- Transitions:
  - EMPTY0: pop -> ONE; otherwise stay.
  - ONE: pop && !acc -> TWO; !pop && acc -> EMPTY0; otherwise stay. Simultaneous pop && acc keeps full throughput.
  - TWO: acc -> ONE (no pop is possible in TWO).
- Data path:
  - On pop, FIFO_RD_DATA is captured at that CLK edge into the tail entry.
  - On acc in TWO, entry 1 shifts to the head.
  - If pop and acc occur in the same cycle in ONE, the new word becomes the head.
- Output timing:
  - OUT_VALID = (state != EMPTY0); OUT_DATA = head entry. Both are registered.
  - Latency: a FIFO word available at edge N is popped at edge N and appears on OUT_DATA/OUT_VALID after edge N, i.e. one cycle.
  - Sustained rate is 1 word/cycle while the FIFO is non-empty and OUT_READY=1.
- Stream rules:
  - Once OUT_VALID is high, OUT_DATA and OUT_LAST hold stable until acc.
  - OUT_VALID never drops without acc, except on FLUSH or RST.
- Burst counter (beat, range 0..BURST_LEN-1):
  - Increments on acc and wraps to 0 after BURST_LEN-1.
  - OUT_LAST = OUT_VALID && (beat == BURST_LEN-1). With BURST_LEN=1, OUT_LAST equals OUT_VALID.
- WORD_CNT: increments by 1 on every acc; wraps from all-ones to 0.
- FLUSH (synchronous, takes priority over acc):
  - Next state EMPTY0, beat=0. Buffered words are dropped.
  - FIFO_RD_INC=0 during the FLUSH cycle.
  - WORD_CNT is unchanged; acc is not counted in a FLUSH cycle.
- FIFO_EMPTY asserted: no pop. The buffer continues draining downstream.
- OUT_READY held low: the buffer fills to TWO, then FIFO_RD_INC stays 0 and the FIFO backs up. No word is lost or duplicated.

Test Plan:
- Reset/idle: RST=1 then 0 with FIFO_EMPTY=1 -> all outputs 0, FIFO_RD_INC never high.
- Streaming: FIFO holds 0x11,0x22,0x33,0x44,0x55 and OUT_READY=1 constantly -> FIFO_RD_INC high 5 consecutive cycles. OUT_DATA is 0x11..0x55 on consecutive cycles starting one cycle after the first pop. OUT_LAST is high only on 0x44 (BURST_LEN=4). WORD_CNT ends at 5.
- Backpressure: FIFO holds 8 words, OUT_READY=0 -> exactly 2 pops, then FIFO_RD_INC=0 and OUT_DATA stable at word 0. Release OUT_READY -> all 8 words delivered in order with no duplicates.
- Bubbling ready: OUT_READY toggles 1,0,1,0 with 6 words queued -> 6 words delivered in order. OUT_LAST is high on the 4th accepted word and on no other.
- FLUSH mid-burst: 2 words accepted, state TWO, assert FLUSH one cycle with OUT_READY=1 -> OUT_VALID=0 next cycle and WORD_CNT stays 2. The next accepted word has beat 0, so OUT_LAST is first high on the 4th word after the flush.
- Async reset mid-operation and counter wrap: RST pulsed between clock edges while in ONE -> OUT_VALID drops immediately, without waiting for a clock edge. Separately, with CNT_WIDTH=4, accept 17 words -> WORD_CNT=1.
